// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared types and default widths for the write-back stage
// Contents: FSM state enum, write-data source enum, default parameter values.
package writeback_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_RADDR_W     = 4;
    localparam int DEF_IMM_W       = 4;
    localparam int DEF_MEM_TIMEOUT = 15;
    localparam int DEF_ZERO_REG    = 0;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_MEM
    } wb_state_e;

    typedef enum logic [2:0] {
        SRC_IMM,
        SRC_MEM,
        SRC_SHIFT,
        SRC_LINK,
        SRC_COPY,
        SRC_ALU
    } wb_src_e;

endpackage

// File: rtl/writeback_if.sv
// rtl/writeback_if.sv - instruction/handshake, memory, register-file and forwarding bundle
// slave  : the write-back stage (consumes instruction + load data, drives rf/fwd/timeout)
// master : the surrounding pipeline (drives instruction + load data)
interface writeback_if
    import writeback_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int IMM_W   = DEF_IMM_W
);
    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] in_rd;
    logic               in_we;
    logic               is_loadi;
    logic               is_load;
    logic               jump;
    logic               copyreg;
    logic [1:0]         shift_ctrl;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  alu_result;
    logic [DATA_W-1:0]  shift_out;
    logic [DATA_W-1:0]  reg2_data;
    logic [DATA_W-1:0]  pc_next;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_rvalid;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic               fwd_valid;
    logic [RADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0]  fwd_data;
    logic               load_timeout;

    modport slave (
        input  in_valid, in_rd, in_we, is_loadi, is_load, jump, copyreg, shift_ctrl, imm,
               alu_result, shift_out, reg2_data, pc_next, mem_rdata, mem_rvalid,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data, load_timeout
    );

    modport master (
        output in_valid, in_rd, in_we, is_loadi, is_load, jump, copyreg, shift_ctrl, imm,
               alu_result, shift_out, reg2_data, pc_next, mem_rdata, mem_rvalid,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data, load_timeout
    );

endinterface

// File: rtl/wb_source_mux.sv
// rtl/wb_source_mux.sv - priority select of the write-back data source
// Inputs : decode source flags, immediate and candidate data words
// Outputs: o_src (selected source), o_data (selected data, immediate zero-extended)
module wb_source_mux
    import writeback_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic              i_is_loadi,
    input  logic              i_is_load,
    input  logic [1:0]        i_shift_ctrl,
    input  logic              i_jump,
    input  logic              i_copyreg,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_shift_out,
    input  logic [DATA_W-1:0] i_reg2_data,
    input  logic [DATA_W-1:0] i_pc_next,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output wb_src_e           o_src,
    output logic [DATA_W-1:0] o_data
);
    wb_src_e w_src;

    always_comb begin
        w_src = SRC_ALU;
        if (i_is_loadi)          w_src = SRC_IMM;
        else if (i_is_load)      w_src = SRC_MEM;
        else if (|i_shift_ctrl)  w_src = SRC_SHIFT;
        else if (i_jump)         w_src = SRC_LINK;
        else if (i_copyreg)      w_src = SRC_COPY;
    end

    always_comb begin
        o_data = i_alu_result;
        case (w_src)
            SRC_IMM:   o_data = DATA_W'(i_imm);
            SRC_MEM:   o_data = i_mem_rdata;
            SRC_SHIFT: o_data = i_shift_out;
            SRC_LINK:  o_data = i_pc_next;
            SRC_COPY:  o_data = i_reg2_data;
            default:   o_data = i_alu_result;
        endcase
    end

    assign o_src = w_src;

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - registered register-file write-back with load wait/timeout and forwarding
// clk, reset : clock and synchronous active-high reset
// bus        : writeback_if.slave (instruction handshake, load data, rf write, forwarding, timeout)
module writeback_stage
    import writeback_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RADDR_W     = DEF_RADDR_W,
    parameter int IMM_W       = DEF_IMM_W,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int ZERO_REG    = DEF_ZERO_REG
) (
    input  logic       clk,
    input  logic       reset,
    writeback_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    wb_state_e          r_state;
    wb_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [RADDR_W-1:0] r_pend_rd;
    logic               r_pend_we;
    logic               r_rf_we;
    logic [RADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0]  r_rf_wdata;
    logic               r_load_timeout;

    wb_src_e            w_src;
    logic [DATA_W-1:0]  w_mux_data;
    logic               w_accept;
    logic               w_issue;
    logic               w_issue_we;
    logic [RADDR_W-1:0] w_issue_addr;
    logic [DATA_W-1:0]  w_issue_data;
    logic               w_latch;
    logic               w_timeout;
    logic               w_write;

    wb_source_mux #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_mux (
        .i_is_loadi   (bus.is_loadi),
        .i_is_load    (bus.is_load),
        .i_shift_ctrl (bus.shift_ctrl),
        .i_jump       (bus.jump),
        .i_copyreg    (bus.copyreg),
        .i_imm        (bus.imm),
        .i_alu_result (bus.alu_result),
        .i_shift_out  (bus.shift_out),
        .i_reg2_data  (bus.reg2_data),
        .i_pc_next    (bus.pc_next),
        .i_mem_rdata  (bus.mem_rdata),
        .o_src        (w_src),
        .o_data       (w_mux_data)
    );

    // in_ready depends on state only, so there is no in_valid -> in_ready path.
    assign bus.in_ready = (r_state == IDLE);
    assign w_accept     = bus.in_valid && (r_state == IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_issue      = 1'b0;
        w_issue_we   = 1'b0;
        w_issue_addr = bus.in_rd;
        w_issue_data = w_mux_data;
        w_latch      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // A load whose data is already valid completes like any other source;
                    // the mux already routes mem_rdata for SRC_MEM.
                    if ((w_src != SRC_MEM) || bus.mem_rvalid) begin
                        w_issue    = 1'b1;
                        w_issue_we = bus.in_we;
                    end else begin
                        w_latch     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                w_cnt_nxt = r_cnt + 1'b1;
                // Data arriving on the final cycle still wins over the timeout.
                if (bus.mem_rvalid) begin
                    w_issue      = 1'b1;
                    w_issue_we   = r_pend_we;
                    w_issue_addr = r_pend_rd;
                    w_issue_data = bus.mem_rdata;
                    w_state_nxt  = IDLE;
                end else if (w_cnt_nxt == CNT_W'(MEM_TIMEOUT)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_write = w_issue && w_issue_we && !((ZERO_REG != 0) && (w_issue_addr == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_pend_rd      <= '0;
            r_pend_we      <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_load_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rf_we        <= w_write;
            r_load_timeout <= w_timeout;
            if (w_latch) begin
                r_pend_rd <= bus.in_rd;
                r_pend_we <= bus.in_we;
            end
            // Address/data only move on a real write, so the forwarding copy holds otherwise.
            if (w_write) begin
                r_rf_waddr <= w_issue_addr;
                r_rf_wdata <= w_issue_data;
            end
        end
    end

    assign bus.rf_we        = r_rf_we;
    assign bus.rf_waddr     = r_rf_waddr;
    assign bus.rf_wdata     = r_rf_wdata;
    assign bus.fwd_valid    = r_rf_we && (r_state == IDLE);
    assign bus.fwd_addr     = r_rf_waddr;
    assign bus.fwd_data     = r_rf_wdata;
    assign bus.load_timeout = r_load_timeout;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    writeback_if #(.DATA_W(16), .RADDR_W(4), .IMM_W(4)) wb ();

    writeback_stage #(
        .DATA_W      (16),
        .RADDR_W     (4),
        .IMM_W       (4),
        .MEM_TIMEOUT (4),
        .ZERO_REG    (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wb.in_valid   = 1'b0;
        wb.in_rd      = '0;
        wb.in_we      = 1'b1;
        wb.is_loadi   = 1'b0;
        wb.is_load    = 1'b0;
        wb.jump       = 1'b0;
        wb.copyreg    = 1'b0;
        wb.shift_ctrl = 2'b00;
        wb.imm        = '0;
        wb.alu_result = 16'h0000;
        wb.shift_out  = 16'h0000;
        wb.reg2_data  = 16'h0000;
        wb.pc_next    = 16'h0000;
        wb.mem_rdata  = 16'h0000;
        wb.mem_rvalid = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [3:0] addr, input logic [15:0] data);
        chk({tag, "_we"},    wb.rf_we, 1'b1);
        chk({tag, "_addr"},  wb.rf_waddr, addr);
        chk({tag, "_data"},  wb.rf_wdata, data);
        chk({tag, "_fwdv"},  wb.fwd_valid, 1'b1);
        chk({tag, "_fwda"},  wb.fwd_addr, addr);
        chk({tag, "_fwdd"},  wb.fwd_data, data);
    endtask

    initial begin
        clr();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", wb.in_ready, 1'b1);
        chk("rst_we",    wb.rf_we, 1'b0);
        chk("rst_waddr", wb.rf_waddr, 4'h0);
        chk("rst_wdata", wb.rf_wdata, 16'h0000);
        chk("rst_fwdv",  wb.fwd_valid, 1'b0);
        chk("rst_fwda",  wb.fwd_addr, 4'h0);
        chk("rst_fwdd",  wb.fwd_data, 16'h0000);
        chk("rst_tmo",   wb.load_timeout, 1'b0);

        // load-immediate
        clr(); wb.in_valid = 1'b1; wb.is_loadi = 1'b1; wb.imm = 4'hA; wb.in_rd = 4'd3;
        tick(); clr();
        chk_write("loadi", 4'd3, 16'h000A);
        tick();
        chk("loadi_once",  wb.rf_we, 1'b0);
        chk("loadi_fwdv0", wb.fwd_valid, 1'b0);
        chk("loadi_hold",  wb.fwd_data, 16'h000A);

        // priority: immediate beats load/shift/jump, no wait state
        clr(); wb.in_valid = 1'b1; wb.is_loadi = 1'b1; wb.is_load = 1'b1; wb.shift_ctrl = 2'b01;
        wb.jump = 1'b1; wb.imm = 4'h5; wb.in_rd = 4'd7; wb.shift_out = 16'h1111; wb.pc_next = 16'h2222;
        tick(); clr();
        chk("prio_ready", wb.in_ready, 1'b1);
        chk_write("prio", 4'd7, 16'h0005);

        // load with rvalid three cycles later
        clr(); wb.in_valid = 1'b1; wb.is_load = 1'b1; wb.in_rd = 4'd5;
        tick(); clr();
        for (int i = 0; i < 3; i++) begin
            chk("ld_wait_ready", wb.in_ready, 1'b0);
            chk("ld_wait_we",    wb.rf_we, 1'b0);
            chk("ld_wait_fwdv",  wb.fwd_valid, 1'b0);
            if (i == 2) begin
                wb.mem_rvalid = 1'b1;
                wb.mem_rdata  = 16'hBEEF;
            end
            tick();
        end
        clr();
        chk_write("ld", 4'd5, 16'hBEEF);
        chk("ld_ready", wb.in_ready, 1'b1);

        // load completing in the handshake cycle
        clr(); wb.in_valid = 1'b1; wb.is_load = 1'b1; wb.in_rd = 4'd9;
        wb.mem_rvalid = 1'b1; wb.mem_rdata = 16'hCAFE;
        tick(); clr();
        chk_write("ldfast", 4'd9, 16'hCAFE);
        chk("ldfast_ready", wb.in_ready, 1'b1);

        // back-to-back shift, link, copy
        clr(); wb.in_valid = 1'b1; wb.shift_ctrl = 2'b10; wb.jump = 1'b1; wb.in_rd = 4'd2;
        wb.shift_out = 16'h5A5A; wb.pc_next = 16'h0F0F;
        tick();
        chk_write("shift", 4'd2, 16'h5A5A);
        clr(); wb.in_valid = 1'b1; wb.jump = 1'b1; wb.copyreg = 1'b1; wb.in_rd = 4'd4;
        wb.pc_next = 16'h0100; wb.reg2_data = 16'h3333;
        tick();
        chk_write("link", 4'd4, 16'h0100);
        clr(); wb.in_valid = 1'b1; wb.copyreg = 1'b1; wb.in_rd = 4'd6;
        wb.reg2_data = 16'h7777; wb.alu_result = 16'h9999;
        tick(); clr();
        chk_write("copy", 4'd6, 16'h7777);

        // timeout after four wait cycles, then stray rvalid in IDLE
        clr(); wb.in_valid = 1'b1; wb.is_load = 1'b1; wb.in_rd = 4'd8;
        tick(); clr();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_wait_ready", wb.in_ready, 1'b0);
            chk("tmo_wait_pulse", wb.load_timeout, 1'b0);
            tick();
        end
        chk("tmo_pulse", wb.load_timeout, 1'b1);
        chk("tmo_no_we", wb.rf_we, 1'b0);
        chk("tmo_ready", wb.in_ready, 1'b1);
        wb.mem_rvalid = 1'b1; wb.mem_rdata = 16'hDEAD;
        tick(); clr();
        chk("tmo_pulse_once", wb.load_timeout, 1'b0);
        chk("stray_rvalid_we", wb.rf_we, 1'b0);
        chk("stray_hold",      wb.fwd_data, 16'h7777);

        // rvalid on the timeout cycle wins
        clr(); wb.in_valid = 1'b1; wb.is_load = 1'b1; wb.in_rd = 4'd10;
        tick(); clr();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                wb.mem_rvalid = 1'b1;
                wb.mem_rdata  = 16'h4321;
            end
            tick();
        end
        clr();
        chk_write("edge", 4'd10, 16'h4321);
        chk("edge_no_tmo", wb.load_timeout, 1'b0);

        // zero-register suppression, ALU source, in_we=0
        clr(); wb.in_valid = 1'b1; wb.alu_result = 16'h1234; wb.in_rd = 4'd0;
        tick();
        chk("zr_we",   wb.rf_we, 1'b0);
        chk("zr_hold", wb.fwd_data, 16'h4321);
        clr(); wb.in_valid = 1'b1; wb.alu_result = 16'h1234; wb.in_rd = 4'd1;
        tick();
        chk_write("alu", 4'd1, 16'h1234);
        clr(); wb.in_valid = 1'b1; wb.alu_result = 16'h5555; wb.in_rd = 4'd2; wb.in_we = 1'b0;
        tick(); clr();
        chk("nowe_we", wb.rf_we, 1'b0);

        // reset while waiting for memory
        clr(); wb.in_valid = 1'b1; wb.is_load = 1'b1; wb.in_rd = 4'd11;
        tick(); clr();
        chk("rstw_wait", wb.in_ready, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wb.mem_rvalid = 1'b1; wb.mem_rdata = 16'hAAAA;
        chk("rstw_ready", wb.in_ready, 1'b1);
        tick(); clr();
        chk("rstw_we",   wb.rf_we, 1'b0);
        chk("rstw_tmo",  wb.load_timeout, 1'b0);
        chk("rstw_fwdd", wb.fwd_data, 16'h0000);
        tick();
        chk("rstw_tmo2", wb.load_timeout, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
